// File: rtl/quant_relu_wb_pkg.sv
// Shared types and defaults for the quantize/ReLU/write-back block.
//   qwb_states_t : write-back FSM states
//   QWB_ACC_W    : default signed accumulator width of incoming AC3 results
//   QWB_ACT_W    : default unsigned activation width written to memory
package quant_relu_wb_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    READY   = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } qwb_states_t;

  localparam int QWB_ACC_W = 24;
  localparam int QWB_ACT_W = 8;

endpackage

// File: rtl/quant_relu_unit.sv
// Combinational quantizer: arithmetic right shift with optional rounding,
// ReLU clamp at zero, and saturation to an unsigned ACT_W-bit activation.
// Build option: QUANT_ROUND_EN defined -> round half up, else truncate (floor).
// Ports:
//   x   in  ACC_W  signed accumulator value
//   s   in  SHW    shift amount
//   q   out ACT_W  quantized activation
//   sat out 1      result was clipped at the activation maximum
module quant_relu_unit
  import quant_relu_wb_pkg::*;
#(
  parameter int ACC_W = QWB_ACC_W,
  parameter int ACT_W = QWB_ACT_W,
  parameter int SHW   = 5
) (
  input  logic signed [ACC_W-1:0] x,
  input  logic        [SHW-1:0]   s,
  output logic        [ACT_W-1:0] q,
  output logic                    sat
);

  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((1 << ACT_W) - 1);

  // One guard bit so that adding the rounding term to the largest positive
  // accumulator value cannot wrap negative.
  logic signed [ACC_W:0] x_ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    x_ext = {x[ACC_W-1], x};
`ifdef QUANT_ROUND_EN
    rnd = (s != '0) ? ((ACC_W+1)'(1) << (s - 1'b1)) : '0;
`else
    rnd = '0;
`endif
    sum     = x_ext + rnd;
    shifted = sum >>> s;
    sat     = 1'b0;
    if (shifted < 0) begin
      q = '0;
    end else if (shifted > Q_MAX) begin
      q   = Q_MAX[ACT_W-1:0];
      sat = 1'b1;
    end else begin
      q = shifted[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/quant_relu_wb.sv
// Quantizes AC3 results into a NUM_FIL-entry buffer, flags the completed set
// with done_quant, then streams the set to activation memory on wb & act_wb and
// pulses relu_done once the last entry is written.
// Build option: QUANT_ROUND_EN (rounding in quant_relu_unit).
// Handshake: an entry is written to memory in every WRITE cycle where wb and
// act_wb are both high (mem_we=1); with either low the stream pauses and
// rd_ptr holds, so no entry is skipped or repeated.
// Ports:
//   clk, rst              clock, async active-high reset
//   cl_en_gen             synchronous clear of pointers, state, flags
//   valid_ac3, ac3_data   incoming AC3 result
//   shift_amt             quantization shift
//   base_addr             write-back base, latched when the set completes
//   wb, act_wb            write-back enable / qualifier
//   done_quant            buffer holds a full quantized set
//   relu_done             one-cycle pulse after the last write
//   mem_we/addr/wdata     activation memory write port (0 when idle)
//   ovf_flag, ovr_err     sticky saturation / dropped-input flags
//   fsm_state             current FSM state (debug)
module quant_relu_wb
  import quant_relu_wb_pkg::*;
#(
  parameter int NUM_FIL = 4,
  parameter int ACC_W   = QWB_ACC_W,
  parameter int ACT_W   = QWB_ACT_W,
  parameter int ADDR_W  = 10,
  parameter int SHW     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cl_en_gen,
  input  logic                    valid_ac3,
  input  logic signed [ACC_W-1:0] ac3_data,
  input  logic        [SHW-1:0]   shift_amt,
  input  logic        [ADDR_W-1:0] base_addr,
  input  logic                    wb,
  input  logic                    act_wb,
  output logic                    done_quant,
  output logic                    relu_done,
  output logic                    mem_we,
  output logic        [ADDR_W-1:0] mem_addr,
  output logic        [ACT_W-1:0] mem_wdata,
  output logic                    ovf_flag,
  output logic                    ovr_err,
  output qwb_states_t             fsm_state
);

  localparam int PTR_W = (NUM_FIL > 1) ? $clog2(NUM_FIL) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_FIL - 1);

  qwb_states_t       state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ACT_W-1:0]  buf_mem [NUM_FIL];
  logic [ADDR_W-1:0] base_q;
  logic [ACT_W-1:0]  q;
  logic              sat;
  logic              wr_go;

  quant_relu_unit #(
    .ACC_W (ACC_W),
    .ACT_W (ACT_W),
    .SHW   (SHW)
  ) u_quant (
    .x   (ac3_data),
    .s   (shift_amt),
    .q   (q),
    .sat (sat)
  );

  // Write port is purely a function of state/regs so an async reset kills an
  // in-flight write in the same cycle.
  assign wr_go     = (state == WRITE) && wb && act_wb;
  assign mem_we    = wr_go;
  assign mem_addr  = wr_go ? base_q + ADDR_W'(rd_ptr) : '0;
  assign mem_wdata = wr_go ? buf_mem[rd_ptr] : '0;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      base_q     <= '0;
      done_quant <= 1'b0;
      relu_done  <= 1'b0;
      ovf_flag   <= 1'b0;
      ovr_err    <= 1'b0;
      for (int i = 0; i < NUM_FIL; i++) buf_mem[i] <= '0;
    end else if (cl_en_gen) begin
      state      <= COLLECT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done_quant <= 1'b0;
      relu_done  <= 1'b0;
      ovf_flag   <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      relu_done <= 1'b0;
      // Results arriving while a set is held or draining are dropped.
      if (valid_ac3 && state != COLLECT) ovr_err <= 1'b1;
      case (state)
        COLLECT: begin
          if (valid_ac3) begin
            buf_mem[wr_ptr] <= q;
            if (sat) ovf_flag <= 1'b1;
            if (wr_ptr == LAST) begin
              state      <= READY;
              base_q     <= base_addr;
              done_quant <= 1'b1;
              wr_ptr     <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        READY: begin
          if (wb && act_wb) begin
            state  <= WRITE;
            rd_ptr <= '0;
          end
        end
        WRITE: begin
          if (wr_go) begin
            if (rd_ptr == LAST) begin
              state      <= DONE;
              done_quant <= 1'b0;
              relu_done  <= 1'b1;
              rd_ptr     <= '0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= COLLECT;
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
